// File: rtl/i2c_slave_mem_arb_pkg.sv
// Shared definitions for the I2C slave register-memory arbiter.
//  state_t : arbiter FSM states
//  tmr_w() : width of the access-timeout down-counter for a given timeout
package i2c_slave_mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GNT_A = 3'd1,
    ST_GNT_B = 3'd2,
    ST_WP_A  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // The counter is loaded with timeout-1, so clog2(timeout) bits suffice.
  // Keep at least one bit for tiny timeouts.
  function automatic int tmr_w(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/i2c_slave_arb_timer.sv
// Loadable down-counter that bounds one memory access.
//  clk, rst_n : clock, async active-low reset
//  clr        : force count to 0 (dominates load)
//  load       : load load_val (start of an access)
//  load_val   : initial count
//  run        : count down this cycle (memory request active)
//  expire     : run is high and the count has reached 0 (last allowed cycle)
module i2c_slave_arb_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (clr)                  cnt <= '0;
    else if (load)                 cnt <= load_val;
    else if (run && cnt != '0)     cnt <= cnt - 1'b1;
  end

  assign expire = run && (cnt == '0);

endmodule

// File: rtl/i2c_slave_mem_arb.sv
// Two-requester arbiter in front of the I2C slave register memory.
//  Port A (a_*) : I2C slave bus side, subject to write protect (wp)
//  Port B (b_*) : local host side, never write protected
//  Memory (m_*) : single shared addr/wdata/wr/en/ack port
//  busy         : FSM not idle
// A has priority, but after P_A_BURST back-to-back A grants with B waiting,
// B gets the next grant. Every access is bounded by P_TIMEOUT cycles of m_en.
module i2c_slave_mem_arb
  import i2c_slave_mem_arb_pkg::*;
#(
  parameter int P_ADDR_LEN = 8,
  parameter int P_A_BURST  = 4,
  parameter int P_TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [P_ADDR_LEN-1:0] a_addr,
  input  logic [7:0]            a_wdata,
  input  logic                  a_wr,
  input  logic                  a_en,
  output logic [7:0]            a_rdata,
  output logic                  a_ack,
  output logic                  a_err,
  input  logic [P_ADDR_LEN-1:0] b_addr,
  input  logic [7:0]            b_wdata,
  input  logic                  b_wr,
  input  logic                  b_en,
  output logic [7:0]            b_rdata,
  output logic                  b_ack,
  output logic                  b_err,
  input  logic                  wp,
  output logic [P_ADDR_LEN-1:0] m_addr,
  output logic [7:0]            m_wdata,
  output logic                  m_wr,
  output logic                  m_en,
  input  logic [7:0]            m_rdata,
  input  logic                  m_ack,
  output logic                  busy
);

  localparam int TW = tmr_w(P_TIMEOUT);
  localparam int SW = $clog2(P_A_BURST + 1);
  localparam logic [SW-1:0] BURST   = SW'(P_A_BURST);
  localparam logic [TW-1:0] TMR_LD  = TW'(P_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [SW-1:0] a_streak;
  logic          gnt_a, gnt_b, a_blocked, mem_start, tmr_exp;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    a_blocked = a_wr && wp;
    m_en      = (state == ST_GNT_A) || (state == ST_GNT_B);
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        // A wins unless it has used up its burst allowance while B waits
        if (a_en && (!b_en || a_streak != BURST)) gnt_a = 1'b1;
        else if (b_en)                            gnt_b = 1'b1;
        if (gnt_a)      state_nxt = a_blocked ? ST_WP_A : ST_GNT_A;
        else if (gnt_b) state_nxt = ST_GNT_B;
      end
      ST_GNT_A, ST_GNT_B: if (m_ack || tmr_exp) state_nxt = ST_DONE;
      ST_WP_A:            state_nxt = ST_DONE;
      ST_DONE:            state_nxt = ST_IDLE;
      default:            state_nxt = ST_IDLE;
    endcase
  end

  // Grant that actually drives the memory (a write-protected A grant does not)
  assign mem_start = (gnt_a && !a_blocked) || gnt_b;

  i2c_slave_arb_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == ST_DONE),
    .load     (mem_start),
    .load_val (TMR_LD),
    .run      (m_en),
    .expire   (tmr_exp)
  );

  // ---------------- fairness streak ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) a_streak <= '0;
    else if (state == ST_IDLE) begin
      if (gnt_b || !b_en)                 a_streak <= '0;
      else if (gnt_a && a_streak != BURST) a_streak <= a_streak + 1'b1;
    end
  end

  // ---------------- memory request latch ----------------
  // Captured at grant so requester changes mid-access are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr  <= '0;
      m_wdata <= '0;
      m_wr    <= 1'b0;
    end else if (mem_start) begin
      m_addr  <= gnt_a ? a_addr  : b_addr;
      m_wdata <= gnt_a ? a_wdata : b_wdata;
      m_wr    <= gnt_a ? a_wr    : b_wr;
    end
  end

  // ---------------- responses ----------------
  // ack/err are single-cycle pulses landing in DONE; rdata holds until the
  // port's next ack. m_ack takes priority over a coincident timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ack <= 1'b0; a_err <= 1'b0; a_rdata <= '0;
      b_ack <= 1'b0; b_err <= 1'b0; b_rdata <= '0;
    end else begin
      a_ack <= 1'b0; a_err <= 1'b0;
      b_ack <= 1'b0; b_err <= 1'b0;
      case (state)
        ST_GNT_A:
          if (m_ack) begin
            a_ack <= 1'b1; a_rdata <= m_wr ? 8'h00 : m_rdata;
          end else if (tmr_exp) begin
            a_ack <= 1'b1; a_err <= 1'b1; a_rdata <= 8'hFF;
          end
        ST_GNT_B:
          if (m_ack) begin
            b_ack <= 1'b1; b_rdata <= m_wr ? 8'h00 : m_rdata;
          end else if (tmr_exp) begin
            b_ack <= 1'b1; b_err <= 1'b1; b_rdata <= 8'hFF;
          end
        ST_WP_A: begin
          a_ack <= 1'b1; a_err <= 1'b1; a_rdata <= 8'h00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_mem_arb.sv
// Directed self-checking bench for i2c_slave_mem_arb.
// A small memory model answers m_en after a programmable number of cycles
// (cycle 1 = first cycle m_en is high); its contents after reset are
// addr ^ 8'hB5, so 8'h10 reads 8'hA5.
module tb_i2c_slave_mem_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic       a_wr = 1'b0, a_en = 1'b0, b_wr = 1'b0, b_en = 1'b0, wp = 1'b0;
  logic [7:0] a_rdata, b_rdata, m_addr, m_wdata, m_rdata;
  logic       a_ack, a_err, b_ack, b_err, m_wr, m_en, m_ack, busy;

  int pass_cnt = 0;
  int total    = 0;

  // memory model controls
  int   mem_delay = 1;
  bit   mem_on = 1'b1;
  bit   m_ack_force = 1'b0;
  int   cyc = 0;
  logic [7:0] mem [256];

  // monitors (counted on negedge, read by tasks at negedge+1)
  int a_acks = 0, b_acks = 0, men_cyc = 0;

  always #5 clk = ~clk;

  i2c_slave_mem_arb #(.P_ADDR_LEN(8), .P_A_BURST(4), .P_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_wr(a_wr), .a_en(a_en),
    .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_wr(b_wr), .b_en(b_en),
    .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
    .wp(wp),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wr(m_wr), .m_en(m_en),
    .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy)
  );

  always @(posedge clk) begin
    if (m_en) cyc <= cyc + 1;
    else      cyc <= 0;
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hB5;
    end else if (m_en && m_ack && m_wr) begin
      mem[m_addr] <= m_wdata;
    end
  end

  assign m_ack   = m_ack_force | (m_en & mem_on & (cyc + 1 == mem_delay));
  assign m_rdata = mem[m_addr];

  always @(negedge clk) begin
    if (a_ack) a_acks++;
    if (b_ack) b_acks++;
    if (m_en)  men_cyc++;
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  // Issue one access and wait (bounded) for its ack. lat = negedges from
  // driving en to seeing ack, or -1 on no ack.
  task automatic access(input bit pb, input logic [7:0] addr, input logic [7:0] wd,
                        input bit wr, output logic [7:0] rd, output logic err,
                        output int lat);
    step();
    if (pb) begin b_addr = addr; b_wdata = wd; b_wr = wr; b_en = 1'b1; end
    else    begin a_addr = addr; a_wdata = wd; a_wr = wr; a_en = 1'b1; end
    lat = -1; rd = 'x; err = 'x;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (pb ? b_ack : a_ack) begin
        lat = i; rd = pb ? b_rdata : a_rdata; err = pb ? b_err : a_err;
        break;
      end
    end
    a_en = 1'b0; b_en = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, m_addr, m_wdata, m_wr, m_en, busy} !== '0)
      $display("FAIL reset_outputs: got nonzero outputs in reset, required all 0");
    else pass_cnt++;
    step(); step();
    rst_n = 1'b1;
    step(); step();
    total++;
    if ({a_ack, b_ack, m_en, busy} !== 4'b0)
      $display("FAIL post_reset_idle: got %b required 0000", {a_ack, b_ack, m_en, busy});
    else pass_cnt++;
  endtask

  task automatic test_single_read();
    logic [7:0] rd; logic err; int lat, a0, b0;
    mem_on = 1'b1; mem_delay = 1;
    a0 = a_acks; b0 = b_acks;
    access(1'b1, 8'h10, 8'h00, 1'b0, rd, err, lat);
    step(); step();
    total++; if (rd !== 8'hA5) $display("FAIL single_rdata: got %h required a5", rd); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL single_err: got %b required 0", err); else pass_cnt++;
    total++; if (lat != 2) $display("FAIL single_latency: got %0d required 2", lat); else pass_cnt++;
    total++;
    if (b_acks - b0 != 1 || a_acks - a0 != 0)
      $display("FAIL single_ack_count: got b=%0d a=%0d required b=1 a=0", b_acks - b0, a_acks - a0);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [9:0] order = '0; int n = 0;
    mem_on = 1'b1; mem_delay = 1;
    step();
    a_addr = 8'h01; a_wr = 1'b0; b_addr = 8'h02; b_wr = 1'b0;
    a_en = 1'b1; b_en = 1'b1;
    for (int i = 0; i < 200 && n < 10; i++) begin
      step();
      if (a_ack || b_ack) begin order[n] = b_ack; n++; end
    end
    a_en = 1'b0; b_en = 1'b0;
    total++; if (n != 10) $display("FAIL contention_count: got %0d grants required 10", n); else pass_cnt++;
    total++;
    if (order !== 10'b10_0001_0000)
      $display("FAIL contention_order: got %b required 1000010000 (bit0 first, 1=B)", order);
    else pass_cnt++;
    total++; if (a_rdata !== 8'hB4) $display("FAIL contention_a_rdata: got %h required b4", a_rdata); else pass_cnt++;
    step(); step();
  endtask

  task automatic test_write_protect();
    logic [7:0] rd; logic err; int lat, m0;
    mem_on = 1'b1; mem_delay = 1;
    wp = 1'b1;
    m0 = men_cyc;
    access(1'b0, 8'h20, 8'h3C, 1'b1, rd, err, lat);
    step();
    total++; if (err !== 1'b1 || lat != 2) $display("FAIL wp_a_err: got err=%b lat=%0d required err=1 lat=2", err, lat); else pass_cnt++;
    total++; if (rd !== 8'h00) $display("FAIL wp_a_rdata: got %h required 00", rd); else pass_cnt++;
    total++; if (men_cyc != m0) $display("FAIL wp_m_en: got %0d m_en cycles required 0", men_cyc - m0); else pass_cnt++;
    m0 = men_cyc;
    access(1'b1, 8'h20, 8'h3C, 1'b1, rd, err, lat);
    step();
    total++; if (err !== 1'b0) $display("FAIL wp_b_err: got %b required 0", err); else pass_cnt++;
    total++; if (men_cyc - m0 != 1) $display("FAIL wp_b_m_en: got %0d m_en cycles required 1", men_cyc - m0); else pass_cnt++;
    wp = 1'b0;
    access(1'b1, 8'h20, 8'h00, 1'b0, rd, err, lat);
    total++; if (rd !== 8'h3C) $display("FAIL wp_b_readback: got %h required 3c", rd); else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic [7:0] rd; logic err; int lat, m0;
    mem_on = 1'b0;
    m0 = men_cyc;
    access(1'b1, 8'h44, 8'h00, 1'b0, rd, err, lat);
    step();
    total++; if (men_cyc - m0 != 16) $display("FAIL timeout_m_en_len: got %0d required 16", men_cyc - m0); else pass_cnt++;
    total++; if (err !== 1'b1 || lat != 17) $display("FAIL timeout_err: got err=%b lat=%0d required err=1 lat=17", err, lat); else pass_cnt++;
    total++; if (rd !== 8'hFF) $display("FAIL timeout_rdata: got %h required ff", rd); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL timeout_idle: got busy=%b required 0", busy); else pass_cnt++;
    mem_on = 1'b1; mem_delay = 16;
    access(1'b1, 8'h44, 8'h00, 1'b0, rd, err, lat);
    total++; if (err !== 1'b0) $display("FAIL ack16_err: got %b required 0", err); else pass_cnt++;
    total++; if (rd !== 8'hF1) $display("FAIL ack16_rdata: got %h required f1", rd); else pass_cnt++;
    total++; if (lat != 17) $display("FAIL ack16_latency: got %0d required 17", lat); else pass_cnt++;
    mem_delay = 1;
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] rd; logic err; int lat;
    mem_on = 1'b0;
    step();
    b_addr = 8'h40; b_wr = 1'b0; b_en = 1'b1;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({m_en, busy, b_ack} !== 3'b000)
      $display("FAIL reset_mid: got m_en,busy,b_ack=%b required 000", {m_en, busy, b_ack});
    else pass_cnt++;
    b_en = 1'b0;
    step(); step();
    rst_n = 1'b1;
    mem_on = 1'b1; mem_delay = 2;
    access(1'b0, 8'h11, 8'h00, 1'b0, rd, err, lat);
    total++; if (rd !== 8'hA4) $display("FAIL post_reset_rdata: got %h required a4", rd); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL post_reset_err: got %b required 0", err); else pass_cnt++;
    total++; if (lat != 3) $display("FAIL post_reset_latency: got %0d required 3", lat); else pass_cnt++;
    mem_delay = 1;
  endtask

  task automatic test_early_drop_spurious();
    int a0, b0;
    bit busy_seen = 1'b0;
    mem_on = 1'b1; mem_delay = 3;
    step();
    a0 = a_acks;
    a_addr = 8'h30; a_wr = 1'b0; a_en = 1'b1;
    step();              // first cycle of GNT_A
    a_en = 1'b0;
    for (int i = 0; i < 8; i++) step();
    total++; if (a_acks - a0 != 1) $display("FAIL early_drop_acks: got %0d required 1", a_acks - a0); else pass_cnt++;
    total++; if (a_rdata !== 8'h85) $display("FAIL early_drop_rdata: got %h required 85", a_rdata); else pass_cnt++;
    a0 = a_acks; b0 = b_acks;
    m_ack_force = 1'b1;
    step();
    busy_seen = busy;
    m_ack_force = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); busy_seen |= busy; end
    total++;
    if (a_acks != a0 || b_acks != b0)
      $display("FAIL spurious_ack: got a=%0d b=%0d extra acks required 0", a_acks - a0, b_acks - b0);
    else pass_cnt++;
    total++; if (busy_seen !== 1'b0) $display("FAIL spurious_state: got busy=1 required 0"); else pass_cnt++;
    mem_delay = 1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_protect();
    test_timeout();
    test_reset_mid_access();
    test_early_drop_spurious();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
